v_ahb_master: RTL

- AHB-Lite master engine sitting directly downstream of the DMA channel controller.
- Consumes the channel's burst command (rush_read/rush_write, addresses, byte length, size, incr) and executes it as pipelined AHB-Lite transfers.
- Moves data between the bus and the channel FIFO.
- Returns next/last/last_write/resp strobes that advance the channel state machine.

---
 rtl/v_dma_pkg.sv | 23 ++
 rtl/v_ahb_beat_cnt.sv | 38 +++
 rtl/v_ahb_master.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/v_dma_pkg.sv
// Shared AHB-Lite encodings and master state type
// for the DMA bus engine.
package v_dma_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DRAIN,
    ST_ERR
  } mst_state_e;

endpackage

// File: rtl/v_ahb_beat_cnt.sv
// Address-phase and data-phase beat counters
// with last-beat flags for one burst.
module v_ahb_beat_cnt #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] beats,
  input  logic             addr_step,
  input  logic             data_step,
  output logic             addr_last,
  output logic             data_last
);

  logic [LEN_W-1:0] total;
  logic [LEN_W-1:0] a_cnt;
  logic [LEN_W-1:0] d_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total <= '0;
      a_cnt <= '0;
      d_cnt <= '0;
    end else if (load) begin
      total <= beats;
      a_cnt <= '0;
      d_cnt <= '0;
    end else begin
      if (addr_step) a_cnt <= a_cnt + 1'b1;
      if (data_step) d_cnt <= d_cnt + 1'b1;
    end
  end

  assign addr_last = (a_cnt == total - LEN_W'(1));
  assign data_last = (d_cnt == total - LEN_W'(1));

endmodule

// File: rtl/v_ahb_master.sv
// AHB-Lite master: runs one channel burst command as
// pipelined transfers and moves data to/from the FIFO.
module v_ahb_master
  import v_dma_pkg::*;
#(
  parameter int BUFFER_SIZE = 4,
  parameter int LEN_W = $clog2(4*BUFFER_SIZE)+1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             cmd_rd_i,
  input  logic             cmd_wr_i,
  input  logic [31:0]      rd_addr_i,
  input  logic [31:0]      wr_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [1:0]       size_i,
  input  logic             incr_i,
  output logic             next_o,
  output logic             last_o,
  output logic             last_write_o,
  output logic             resp_o,
  output logic             fifo_wr_o,
  output logic             fifo_rd_o,
  output logic [31:0]      fifo_wdata_o,
  input  logic [31:0]      fifo_rdata_i,
  output logic [1:0]       fifo_size_o,
  output logic [1:0]       fifo_offset_o,
  output logic [31:0]      haddr_o,
  output logic [1:0]       htrans_o,
  output logic             hwrite_o,
  output logic [2:0]       hsize_o,
  output logic [2:0]       hburst_o,
  output logic [31:0]      hwdata_o,
  input  logic [31:0]      hrdata_i,
  input  logic             hready_i,
  input  logic             hresp_i
);

  mst_state_e       state;
  logic [1:0]       size_q;
  logic             incr_q;
  logic             zero_q;
  logic             dp_valid;
  logic [1:0]       dp_off;
  logic             addr_last;
  logic             data_last;
  logic             cmd;
  logic             load;
  logic             addr_step;
  logic             data_step;
  logic             err;
  logic [LEN_W-1:0] beats_in;
  logic [31:0]      addr_nxt;
  logic             same_kb;

  assign cmd       = cmd_wr_i | cmd_rd_i;
  assign load      = (state == ST_IDLE) & cmd;
  assign beats_in  = len_i >> size_i;
  assign addr_step = (state == ST_ADDR) & hready_i;
  assign data_step = dp_valid & hready_i;
  assign err       = dp_valid & hresp_i & ~hready_i;
  assign addr_nxt  = incr_q ? haddr_o + (32'd1 << size_q) : haddr_o;
  assign same_kb   = (addr_nxt[31:10] == haddr_o[31:10]);

  assign fifo_wr_o     = data_step & ~hwrite_o;
  assign fifo_rd_o     = addr_step & hwrite_o;
  assign fifo_wdata_o  = hrdata_i & {32{fifo_wr_o}};
  assign fifo_size_o   = size_q;
  assign fifo_offset_o = dp_off;

  v_ahb_beat_cnt #(.LEN_W(LEN_W)) u_cnt (
    .clk       (clk),
    .rst_n     (areset),
    .load      (load),
    .beats     (beats_in),
    .addr_step (addr_step),
    .data_step (data_step),
    .addr_last (addr_last),
    .data_last (data_last)
  );

  // data phase of the beat accepted in the previous cycle
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      dp_valid <= 1'b0;
      dp_off   <= 2'd0;
    end else if (err) begin
      dp_valid <= 1'b0;
    end else if (hready_i) begin
      dp_valid <= addr_step;
      if (addr_step) dp_off <= haddr_o[1:0];
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state        <= ST_IDLE;
      size_q       <= 2'd0;
      incr_q       <= 1'b0;
      zero_q       <= 1'b0;
      next_o       <= 1'b0;
      last_o       <= 1'b0;
      last_write_o <= 1'b0;
      resp_o       <= 1'b0;
      haddr_o      <= '0;
      htrans_o     <= HTRANS_IDLE;
      hwrite_o     <= 1'b0;
      hsize_o      <= 3'd0;
      hburst_o     <= HBURST_SINGLE;
      hwdata_o     <= '0;
    end else begin
      next_o       <= 1'b0;
      last_o       <= 1'b0;
      last_write_o <= 1'b0;
      resp_o       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd) begin
            hwrite_o <= cmd_wr_i;
            haddr_o  <= cmd_wr_i ? wr_addr_i : rd_addr_i;
            hsize_o  <= {1'b0, size_i};
            hburst_o <= incr_i ? HBURST_INCR : HBURST_SINGLE;
            size_q   <= size_i;
            incr_q   <= incr_i;
            if (beats_in == '0) begin
              zero_q <= 1'b1;
              next_o <= 1'b1;
              state  <= ST_DRAIN;
            end else begin
              zero_q   <= 1'b0;
              htrans_o <= HTRANS_NONSEQ;
              state    <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (err) begin
            htrans_o <= HTRANS_IDLE;
            resp_o   <= 1'b1;
            state    <= ST_ERR;
          end else if (hready_i) begin
            if (hwrite_o) hwdata_o <= fifo_rdata_i;
            if (addr_last) begin
              htrans_o <= HTRANS_IDLE;
              next_o   <= 1'b1;
              state    <= ST_DRAIN;
            end else begin
              haddr_o  <= addr_nxt;
              htrans_o <= (incr_q && same_kb) ? HTRANS_SEQ
                                              : HTRANS_NONSEQ;
            end
          end
        end
        ST_DRAIN: begin
          if (err) begin
            resp_o <= 1'b1;
            state  <= ST_ERR;
          end else if (zero_q || (hready_i && data_last)) begin
            last_o       <= ~hwrite_o;
            last_write_o <= hwrite_o;
            state        <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (hready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
